mul_operand_sequencer: RTL and testbench

Sequencing stage between the Tiny Tapeout pin interface and the multiplier core in `tt_um_nishit0072e_multiplier`. It captures two operands serially from the 8-bit dedicated inputs on load strobes and launches the core with a one-cycle start pulse. It then latches the core's 2×WIDTH product and presents it one byte at a time on the output pins, with busy, valid and timeout-error status.

---
 rtl/mul_operand_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mul_operand_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mul_operand_sequencer
//
// Sits between the Tiny Tapeout pins and the multiplier core. Two operands are
// captured serially from data_in on rising edges of the load strobe. A one-cycle
// start pulse then launches the core. The 2*WIDTH product is latched on done
// and read back one byte at a time, selected by sel_hi.
//
// Parameters
//   WIDTH           operand width; the product is 2*WIDTH bits
//   TIMEOUT_CYCLES  WAIT cycles allowed before error is flagged (must be >= 2)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   ena       in   design enable; when low, all state holds and start is masked
//   data_in   in   operand byte
//   load      in   operand strobe (level); only rising edges act
//   sel_hi    in   output byte select (1 = upper half of result)
//   op_a      out  registered operand A to the core
//   op_b      out  registered operand B to the core
//   start     out  one-cycle launch pulse to the core
//   product   in   core result, sampled only while done is high in WAIT
//   done      in   one-cycle completion pulse from the core
//   data_out  out  selected byte of the result register
//   phase     out  state: 0 IDLE_A, 1 LOAD_B, 2 START, 3 WAIT
//   busy      out  high in START and WAIT
//   valid     out  result register holds a fresh product
//   error     out  last operation timed out
// -----------------------------------------------------------------------------
module mul_operand_sequencer #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               load,
    input  logic               sel_hi,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic               start,
    input  logic [2*WIDTH-1:0] product,
    input  logic               done,
    output logic [WIDTH-1:0]   data_out,
    output logic [1:0]         phase,
    output logic               busy,
    output logic               valid,
    output logic               error
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    // Last count value before the timeout fires; the counter never goes past it.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdleA = 2'd0,
        StLoadB = 2'd1,
        StStart = 2'd2,
        StWait  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               load_q, load_d;
    logic               load_edge;

    // load_q resets high so a strobe held through reset must drop and rise again.
    assign load_edge = load & ~load_q;
    assign load_d    = load;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        valid_d  = valid_q;
        error_d  = error_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdleA: begin
                if (load_edge) begin
                    op_a_d  = data_in;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    state_d = StLoadB;
                end
            end

            StLoadB: begin
                if (load_edge) begin
                    op_b_d  = data_in;
                    state_d = StStart;
                end
            end

            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                // done takes priority over a timeout landing in the same cycle.
                if (done) begin
                    result_d = product;
                    valid_d  = 1'b1;
                    state_d  = StIdleA;
                end else if (cnt_q == CntLast) begin
                    error_d = 1'b1;
                    state_d = StIdleA;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdleA;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers; ena low freezes everything including the edge detector
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdleA;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            load_q   <= 1'b1;
        end else if (ena) begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign start    = ena & (state_q == StStart);
    assign busy     = (state_q == StStart) | (state_q == StWait);
    assign phase    = state_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign valid    = valid_q;
    assign error    = error_q;
    // Reads the result register only, never the live core product.
    assign data_out = sel_hi ? result_q[2*WIDTH-1:WIDTH] : result_q[WIDTH-1:0];

endmodule

// File: tb/tb_mul_operand_sequencer.sv
module tb_mul_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  data_in;
    logic        load;
    logic        sel_hi;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        start;
    logic [15:0] product;
    logic        done;
    logic [7:0]  data_out;
    logic [1:0]  phase;
    logic        busy;
    logic        valid;
    logic        error;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [15:0] exp_q[$];

    // Core model: done arrives so that it is sampled core_latency edges after
    // the edge that ends the start cycle. core_latency == 0 means never.
    int          core_latency = 8;
    int          core_cnt = 0;
    bit          core_busy = 1'b0;
    logic        model_done = 1'b0;
    logic [15:0] core_prod = 16'h0;
    logic        stray_done = 1'b0;

    assign done    = model_done | stray_done;
    assign product = stray_done ? 16'hBEEF : core_prod;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (start === 1'b1) start_cnt++;
    end

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (rst) begin
            core_busy <= 1'b0;
        end else if (start) begin
            core_busy <= 1'b1;
            core_cnt  <= 1;
            core_prod <= 16'(op_a) * 16'(op_b);
        end else if (core_busy && core_latency != 0) begin
            if (core_cnt == core_latency - 1) begin
                model_done <= 1'b1;
                core_busy  <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    mul_operand_sequencer #(
        .WIDTH         (8),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .data_in (data_in),
        .load    (load),
        .sel_hi  (sel_hi),
        .op_a    (op_a),
        .op_b    (op_b),
        .start   (start),
        .product (product),
        .done    (done),
        .data_out(data_out),
        .phase   (phase),
        .busy    (busy),
        .valid   (valid),
        .error   (error)
    );

    // Raise load with v, let one edge sample it, then drop it for one cycle.
    task automatic load_edge(input logic [7:0] v);
        data_in = v;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) until the FSM is back in IDLE_A; n is negedges consumed.
    task automatic wait_idle(output int n);
        n = 0;
        while (phase != 2'd0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL reset_op_a: got %h want 00", op_a); end
        checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL reset_op_b: got %h want 00", op_b); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if ({phase, busy, valid, error, start} !== 6'b0) begin
            errors++; $display("FAIL reset_status: got %b want 000000", {phase, busy, valid, error, start});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        int s0;
        logic [15:0] e;
        s0 = start_cnt;
        data_in = 8'h0C; load = 1'b1;
        @(negedge clk);
        checks++; if (op_a !== 8'h0C) begin errors++; $display("FAIL basic_op_a: got %h want 0c", op_a); end
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL basic_phase_b: got %0d want 1", phase); end
        load = 1'b0;
        @(negedge clk);
        data_in = 8'h0D; load = 1'b1;
        exp_q.push_back(16'h009C);
        @(negedge clk);
        checks++; if (op_b !== 8'h0D) begin errors++; $display("FAIL basic_op_b: got %h want 0d", op_b); end
        checks++; if ({start, busy, phase} !== 4'b1110) begin
            errors++; $display("FAIL basic_start_cycle: got %b want 1110", {start, busy, phase});
        end
        load = 1'b0;
        @(negedge clk);
        checks++; if ({start, phase} !== 3'b011) begin
            errors++; $display("FAIL basic_wait_entry: got %b want 011", {start, phase});
        end
        wait_idle(n);
        checks++; if (n !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", n); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL basic_start_count: got %0d want 1", start_cnt - s0); end
        checks++; if ({valid, error, busy} !== 3'b100) begin
            errors++; $display("FAIL basic_status: got %b want 100", {valid, error, busy});
        end
        e = exp_q.pop_front();
        sel_hi = 1'b0; #1;
        checks++; if (data_out !== e[7:0]) begin errors++; $display("FAIL basic_lo: got %h want %h", data_out, e[7:0]); end
        sel_hi = 1'b1; #1;
        checks++; if (data_out !== e[15:8]) begin errors++; $display("FAIL basic_hi: got %h want %h", data_out, e[15:8]); end
        sel_hi = 1'b0;
    endtask

    task automatic test_max();
        int n;
        logic [15:0] e;
        core_latency = 8;
        load_edge(8'hFF);
        exp_q.push_back(16'hFE01);
        load_edge(8'hFF);
        wait_idle(n);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b want 1", valid); end
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            sel_hi = i[0]; #1;
            checks++;
            if (data_out !== (sel_hi ? e[15:8] : e[7:0])) begin
                errors++;
                $display("FAIL max_toggle%0d: got %h want %h", i, data_out, sel_hi ? e[15:8] : e[7:0]);
            end
        end
        load_edge(8'h12);
        sel_hi = 1'b1; #1;
        checks++; if ({valid, phase} !== 3'b001) begin errors++; $display("FAIL max_valid_clear: got %b want 001", {valid, phase}); end
        checks++; if (data_out !== 8'hFE) begin errors++; $display("FAIL max_retained: got %h want fe", data_out); end
        sel_hi = 1'b0;
        exp_q.push_back(16'h0024);
        load_edge(8'h02);
        wait_idle(n);
        e = exp_q.pop_front();
        #1;
        checks++; if (data_out !== e[7:0]) begin errors++; $display("FAIL max_next_op: got %h want %h", data_out, e[7:0]); end
    endtask

    task automatic test_load_held_reset();
        int n;
        logic [15:0] e;
        rst = 1'b1; load = 1'b1; data_in = 8'h55;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({op_a, phase} !== 10'h000) begin
            errors++; $display("FAIL held_no_capture: got op_a=%h phase=%0d want 00/0", op_a, phase);
        end
        load = 1'b0;
        @(negedge clk);
        load_edge(8'h33);
        checks++; if ({op_a, phase} !== {8'h33, 2'd1}) begin
            errors++; $display("FAIL held_recapture: got op_a=%h phase=%0d want 33/1", op_a, phase);
        end
        core_latency = 4;
        exp_q.push_back(16'h0099);
        load_edge(8'h03);
        wait_idle(n);
        e = exp_q.pop_front();
        #1;
        checks++; if (data_out !== e[7:0]) begin errors++; $display("FAIL held_result: got %h want %h", data_out, e[7:0]); end
    endtask

    task automatic test_ignore_in_wait();
        int n;
        int s0;
        logic [15:0] e;
        core_latency = 30;
        s0 = start_cnt;
        load_edge(8'h21);
        exp_q.push_back(16'h0084);
        load_edge(8'h04);
        load_edge(8'hAA);
        load_edge(8'hBB);
        load_edge(8'hCC);
        checks++; if ({op_a, op_b, phase} !== {8'h21, 8'h04, 2'd3}) begin
            errors++; $display("FAIL wait_ignore: got %h/%h/%0d want 21/04/3", op_a, op_b, phase);
        end
        wait_idle(n);
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL wait_starts: got %0d want 1", start_cnt - s0); end
        e = exp_q.pop_front();
        #1;
        checks++; if (data_out !== e[7:0]) begin errors++; $display("FAIL wait_result: got %h want %h", data_out, e[7:0]); end
    endtask

    task automatic test_timeout();
        int n;
        logic [15:0] e;
        core_latency = 0;
        load_edge(8'h05);
        data_in = 8'h06; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        checks++; if (n !== 65) begin errors++; $display("FAIL timeout_cycles: got %0d want 65", n); end
        checks++; if ({error, valid, busy} !== 3'b100) begin
            errors++; $display("FAIL timeout_status: got %b want 100", {error, valid, busy});
        end
        load_edge(8'h07);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", error); end
        core_latency = 5;
        exp_q.push_back(16'h0038);
        load_edge(8'h08);
        wait_idle(n);
        e = exp_q.pop_front();
        #1;
        checks++; if (data_out !== e[7:0]) begin errors++; $display("FAIL timeout_recover: got %h want %h", data_out, e[7:0]); end
    endtask

    task automatic test_done_at_timeout();
        int n;
        logic [15:0] e;
        core_latency = 64;
        load_edge(8'h10);
        exp_q.push_back(16'h0110);
        load_edge(8'h11);
        wait_idle(n);
        checks++; if (n !== 64) begin errors++; $display("FAIL tie_cycles: got %0d want 64", n); end
        checks++; if ({valid, error} !== 2'b10) begin errors++; $display("FAIL tie_status: got %b want 10", {valid, error}); end
        e = exp_q.pop_front();
        sel_hi = 1'b1; #1;
        checks++; if (data_out !== e[15:8]) begin errors++; $display("FAIL tie_hi: got %h want %h", data_out, e[15:8]); end
        sel_hi = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        core_latency = 0;
        load_edge(8'h0A);
        load_edge(8'h0B);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({op_a, op_b, data_out, phase, busy, valid, error, start} !== 30'h0) begin
            errors++;
            $display("FAIL rstwait_zero: got %h %h %h %b want all zero", op_a, op_b, data_out,
                     {phase, busy, valid, error, start});
        end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        sel_hi = 1'b1; #1;
        checks++; if ({valid, phase, data_out} !== 11'h0) begin
            errors++; $display("FAIL rstwait_stray: got valid=%b phase=%0d data=%h want 0", valid, phase, data_out);
        end
        sel_hi = 1'b0;
    endtask

    task automatic test_ena_freeze();
        int n;
        int s0;
        core_latency = 0;
        load_edge(8'h02);
        data_in = 8'h03; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        s0 = start_cnt;
        ena = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if ({phase, busy} !== 3'b111) begin errors++; $display("FAIL ena_phase: got %b want 111", {phase, busy}); end
        ena = 1'b1;
        wait_idle(n);
        checks++; if (n !== 55) begin errors++; $display("FAIL ena_counter_frozen: got %0d want 55", n); end
        checks++; if ({error, start_cnt - s0 == 0} !== 2'b11) begin
            errors++; $display("FAIL ena_timeout: got error=%b starts=%0d want 1/0", error, start_cnt - s0);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; load = 1'b0; data_in = 8'h00; sel_hi = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_load_held_reset();
        test_ignore_in_wait();
        test_timeout();
        test_done_at_timeout();
        test_reset_in_wait();
        test_ena_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
